// File: rtl/hsid_pkg.sv
// Shared HSID types and constants: MSE scan scheduler state encoding and default widths.
package hsid_pkg;

    localparam int HSID_WORD_WIDTH                = 32;
    localparam int HSID_HSP_LIBRARY_WIDTH         = 8;
    localparam int HSID_MSE_SCHED_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT,
        DRAIN,
        DONE
    } hsid_mse_sched_state_t;

endpackage

// File: rtl/hsid_mse_sched.sv
// Scan scheduler for one hyperspectral pixel: issues one MSE request per library reference,
// forwards responses to the min/max comparator and latches the result. Optional WAIT watchdog: HSID_MSE_SCHED_TIMEOUT_EN.
module hsid_mse_sched
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
    parameter int TIMEOUT_CYCLES    = HSID_MSE_SCHED_TIMEOUT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [HSP_LIBRARY_WIDTH-1:0] lib_size,
    output logic                         busy,
    output logic                         done,
    output logic                         empty,
    output logic                         ref_err,
    output logic                         timeout,
    output logic                         eng_req_valid,
    input  logic                         eng_req_ready,
    output logic [HSP_LIBRARY_WIDTH-1:0] eng_req_ref,
    input  logic                         eng_rsp_valid,
    input  logic                         eng_rsp_of,
    input  logic [WORD_WIDTH-1:0]        eng_rsp_value,
    input  logic [HSP_LIBRARY_WIDTH-1:0] eng_rsp_ref,
    output logic                         cmp_clear,
    output logic                         cmp_in_valid,
    output logic                         cmp_in_of,
    output logic [WORD_WIDTH-1:0]        cmp_in_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] cmp_in_ref,
    input  logic [WORD_WIDTH-1:0]        cmp_min_value,
    input  logic [HSP_LIBRARY_WIDTH-1:0] cmp_min_ref,
    input  logic [WORD_WIDTH-1:0]        cmp_max_value,
    input  logic [HSP_LIBRARY_WIDTH-1:0] cmp_max_ref,
    output logic [WORD_WIDTH-1:0]        res_min_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] res_min_ref,
    output logic [WORD_WIDTH-1:0]        res_max_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] res_max_ref
);

    localparam logic [HSP_LIBRARY_WIDTH-1:0] LIB_ONE = {{(HSP_LIBRARY_WIDTH-1){1'b0}}, 1'b1};

    hsid_mse_sched_state_t        state, state_nxt;
    logic [HSP_LIBRARY_WIDTH-1:0] idx, idx_nxt;
    logic [HSP_LIBRARY_WIDTH-1:0] size_q;
    logic                         rsp_in_wait;
    logic                         last_ref;
    logic                         timeout_hit;

    // Responses outside WAIT (e.g. stragglers from before a reset) never reach the comparator.
    assign rsp_in_wait = eng_rsp_valid && (state == WAIT);
    assign last_ref    = (idx == size_q - LIB_ONE);

`ifdef HSID_MSE_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != WAIT) wait_cnt <= '0;
        else                      wait_cnt <= wait_cnt + CNT_W'(1);
    end

    assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out; the parameter is still referenced so both builds share one interface.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt     = state;
        idx_nxt       = idx;
        eng_req_valid = 1'b0;
        cmp_clear     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                cmp_clear = 1'b1;
                state_nxt = (size_q == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                eng_req_valid = 1'b1;
                if (eng_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (eng_rsp_valid) begin
                    if (last_ref) begin
                        state_nxt = DRAIN;
                    end else begin
                        idx_nxt   = idx + LIB_ONE;
                        state_nxt = ISSUE;
                    end
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            size_q        <= '0;
            ref_err       <= 1'b0;
            empty         <= 1'b0;
            timeout       <= 1'b0;
            res_min_value <= '1;
            res_min_ref   <= '0;
            res_max_value <= '0;
            res_max_ref   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (state == IDLE && start) begin
                size_q  <= lib_size;
                ref_err <= 1'b0;
                empty   <= 1'b0;
                timeout <= 1'b0;
            end
            if (rsp_in_wait && eng_rsp_ref != idx) ref_err <= 1'b1;
            if (state == CLEAR && size_q == '0)    empty   <= 1'b1;
            if (state == WAIT && !eng_rsp_valid && timeout_hit) timeout <= 1'b1;
            if (state == DONE) begin
                // An empty scan reports the comparator's cleared values without trusting its outputs.
                res_min_value <= empty ? '1 : cmp_min_value;
                res_min_ref   <= empty ? '0 : cmp_min_ref;
                res_max_value <= empty ? '0 : cmp_max_value;
                res_max_ref   <= empty ? '0 : cmp_max_ref;
            end
        end
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign eng_req_ref  = idx;
    assign cmp_in_valid = rsp_in_wait;
    assign cmp_in_of    = rsp_in_wait & eng_rsp_of;
    assign cmp_in_value = rsp_in_wait ? eng_rsp_value : '0;
    assign cmp_in_ref   = rsp_in_wait ? eng_rsp_ref : '0;

endmodule

// File: tb/tb_hsid_mse_sched.sv
// Self-checking bench for hsid_mse_sched with an engine model, a comparator stand-in and a response scoreboard.
module tb_hsid_mse_sched;

    localparam int WW = 32;
    localparam int LW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [LW-1:0] lib_size;
    logic          busy, done, empty, ref_err, timeout;
    logic          eng_req_valid, eng_req_ready;
    logic [LW-1:0] eng_req_ref;
    logic          eng_rsp_valid, eng_rsp_of;
    logic [WW-1:0] eng_rsp_value;
    logic [LW-1:0] eng_rsp_ref;
    logic          cmp_clear, cmp_in_valid, cmp_in_of;
    logic [WW-1:0] cmp_in_value;
    logic [LW-1:0] cmp_in_ref;
    logic [WW-1:0] cmp_min_value, cmp_max_value;
    logic [LW-1:0] cmp_min_ref, cmp_max_ref;
    logic [WW-1:0] res_min_value, res_max_value;
    logic [LW-1:0] res_min_ref, res_max_ref;

    always #5 clk = ~clk;

    hsid_mse_sched #(
        .WORD_WIDTH       (WW),
        .HSP_LIBRARY_WIDTH(LW),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .lib_size     (lib_size),
        .busy         (busy),
        .done         (done),
        .empty        (empty),
        .ref_err      (ref_err),
        .timeout      (timeout),
        .eng_req_valid(eng_req_valid),
        .eng_req_ready(eng_req_ready),
        .eng_req_ref  (eng_req_ref),
        .eng_rsp_valid(eng_rsp_valid),
        .eng_rsp_of   (eng_rsp_of),
        .eng_rsp_value(eng_rsp_value),
        .eng_rsp_ref  (eng_rsp_ref),
        .cmp_clear    (cmp_clear),
        .cmp_in_valid (cmp_in_valid),
        .cmp_in_of    (cmp_in_of),
        .cmp_in_value (cmp_in_value),
        .cmp_in_ref   (cmp_in_ref),
        .cmp_min_value(cmp_min_value),
        .cmp_min_ref  (cmp_min_ref),
        .cmp_max_value(cmp_max_value),
        .cmp_max_ref  (cmp_max_ref),
        .res_min_value(res_min_value),
        .res_min_ref  (res_min_ref),
        .res_max_value(res_max_value),
        .res_max_ref  (res_max_ref)
    );

    // Stand-in for hsid_mse_comp: registered update, <= / >= so ties go to the latest reference.
    always_ff @(posedge clk) begin
        if (rst || cmp_clear) begin
            cmp_min_value <= '1;
            cmp_min_ref   <= '0;
            cmp_max_value <= '0;
            cmp_max_ref   <= '0;
        end else if (cmp_in_valid && !cmp_in_of) begin
            if (cmp_in_value <= cmp_min_value) begin
                cmp_min_value <= cmp_in_value;
                cmp_min_ref   <= cmp_in_ref;
            end
            if (cmp_in_value >= cmp_max_value) begin
                cmp_max_value <= cmp_in_value;
                cmp_max_ref   <= cmp_in_ref;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [WW-1:0] value;
        logic          of;
        logic [LW-1:0] rref;
    } rsp_t;

    rsp_t          sb[$];
    int            lat = 2;
    logic [WW-1:0] vals[16];
    logic          ofs[16];
    int            stall_ref = -1, stall_len = 0, stall_left = 0, stall_bad = 0;
    int            bad_ref = -1;
    logic [LW-1:0] bad_ref_val = '0;
    bit            silent = 1'b0;
    bit            pend = 1'b0;
    int            pend_cnt = 0;
    rsp_t          pend_rsp;
    int            hs_cnt = 0, req_cnt = 0, cmp_cnt = 0, done_cnt = 0;

    // Engine model plus scoreboard monitor, one process so drive and sample order is fixed.
    initial begin
        rsp_t e;
        eng_req_ready = 1'b0;
        eng_rsp_valid = 1'b0;
        eng_rsp_of    = 1'b0;
        eng_rsp_value = '0;
        eng_rsp_ref   = '0;
        forever begin
            @(negedge clk);
            eng_rsp_valid = 1'b0;
            eng_rsp_of    = 1'b0;
            eng_rsp_value = '0;
            eng_rsp_ref   = '0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    eng_rsp_valid = 1'b1;
                    eng_rsp_value = pend_rsp.value;
                    eng_rsp_of    = pend_rsp.of;
                    eng_rsp_ref   = pend_rsp.rref;
                    pend          = 1'b0;
                end
            end
            eng_req_ready = 1'b1;
            if (stall_left > 0 && eng_req_valid === 1'b1 && int'(eng_req_ref) == stall_ref) begin
                eng_req_ready = 1'b0;
                stall_left--;
            end else if (stall_left > 0 && stall_left < stall_len) begin
                stall_bad++;
            end
            if (eng_req_valid === 1'b1) req_cnt++;
            if (eng_req_valid === 1'b1 && eng_req_ready) begin
                hs_cnt++;
                if (!silent) begin
                    pend_rsp.value = vals[eng_req_ref[3:0]];
                    pend_rsp.of    = ofs[eng_req_ref[3:0]];
                    pend_rsp.rref  = (int'(eng_req_ref) == bad_ref) ? bad_ref_val : eng_req_ref;
                    pend           = 1'b1;
                    pend_cnt       = lat;
                    sb.push_back(pend_rsp);
                end
            end
            #1;
            if (done === 1'b1) done_cnt++;
            if (cmp_in_valid === 1'b1) begin
                cmp_cnt++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL cmp_in_unexpected: got value=%0d ref=%0d, required no forward", cmp_in_value, cmp_in_ref);
                end else begin
                    e = sb.pop_front();
                    if ({cmp_in_value, cmp_in_of, cmp_in_ref} !== e) begin
                        bad++;
                        $display("FAIL cmp_in_fwd: got value=%0d of=%0b ref=%0d, required value=%0d of=%0b ref=%0d",
                                 cmp_in_value, cmp_in_of, cmp_in_ref, e.value, e.of, e.rref);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic run_scan(input int n, output int s_cyc);
        lib_size = LW'(n);
        start    = 1'b1;
        s_cyc    = cyc;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int d, output bit ok);
        ok = 1'b0;
        d  = -1;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                d  = cyc;
                return;
            end
            tick();
        end
        total++;
        bad++;
        $display("FAIL done_wait: got no done within %0d cycles, required done", budget);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; lib_size = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++;
        if ({busy, done, empty, ref_err, timeout, eng_req_valid, cmp_clear, cmp_in_valid} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, required 00000000",
                     {busy, done, empty, ref_err, timeout, eng_req_valid, cmp_clear, cmp_in_valid});
        end
        total++;
        if ({res_min_value, res_min_ref, res_max_value, res_max_ref, eng_req_ref} !== {32'hFFFF_FFFF, 8'h0, 32'h0, 8'h0, 8'h0}) begin
            bad++;
            $display("FAIL reset_res: got min=%h/%0d max=%h/%0d req_ref=%0d, required ffffffff/0 0/0 0",
                     res_min_value, res_min_ref, res_max_value, res_max_ref, eng_req_ref);
        end
    endtask

    task automatic test_basic();
        int s, d, hs0;
        bit ok;
        lat = 2;
        vals[0] = 50; vals[1] = 20; vals[2] = 80; vals[3] = 20;
        for (int i = 0; i < 16; i++) ofs[i] = 1'b0;
        hs0 = hs_cnt;
        run_scan(4, s);
        wait_done(60, d, ok);
        if (ok) begin
            total++;
            if (d - s != 2 + 4 * (1 + 2) + 1) begin
                bad++;
                $display("FAIL basic_latency: got %0d, required %0d", d - s, 2 + 4 * 3 + 1);
            end
            total++;
            if ({empty, timeout} !== 2'b00) begin
                bad++;
                $display("FAIL basic_flags: got empty=%b timeout=%b, required 0 0", empty, timeout);
            end
            tick();
            total++;
            if ({res_min_value, res_min_ref, res_max_value, res_max_ref} !== {32'd20, 8'd3, 32'd80, 8'd2}) begin
                bad++;
                $display("FAIL basic_result: got min=%0d/%0d max=%0d/%0d, required 20/3 80/2",
                         res_min_value, res_min_ref, res_max_value, res_max_ref);
            end
            total++;
            if (hs_cnt - hs0 != 4 || busy !== 1'b0) begin
                bad++;
                $display("FAIL basic_handshakes: got hs=%0d busy=%b, required 4 0", hs_cnt - hs0, busy);
            end
        end
    endtask

    task automatic test_empty();
        int s, d, r0;
        bit ok;
        r0 = req_cnt;
        run_scan(0, s);
        wait_done(10, d, ok);
        if (ok) begin
            total++;
            if (d - s != 2 || empty !== 1'b1) begin
                bad++;
                $display("FAIL empty_done: got latency=%0d empty=%b, required 2 1", d - s, empty);
            end
            tick();
            total++;
            if ({res_min_value, res_min_ref, res_max_value, res_max_ref} !== {32'hFFFF_FFFF, 8'd0, 32'd0, 8'd0}) begin
                bad++;
                $display("FAIL empty_result: got min=%h/%0d max=%h/%0d, required ffffffff/0 0/0",
                         res_min_value, res_min_ref, res_max_value, res_max_ref);
            end
            total++;
            if (req_cnt != r0) begin
                bad++;
                $display("FAIL empty_no_req: got %0d request cycles, required 0", req_cnt - r0);
            end
        end
    endtask

    task automatic test_stall();
        int s, d, hs0, d0;
        bit ok;
        lat = 2;
        vals[0] = 7; vals[1] = 3; vals[2] = 9;
        stall_ref = 1; stall_len = 5; stall_left = 5; stall_bad = 0;
        hs0 = hs_cnt;
        d0  = done_cnt;
        run_scan(3, s);
        wait_done(80, d, ok);
        if (ok) begin
            total++;
            if (d - s != 2 + 3 * (1 + 2) + 1 + 5) begin
                bad++;
                $display("FAIL stall_latency: got %0d, required %0d", d - s, 2 + 9 + 1 + 5);
            end
            tick();
            total++;
            if ({res_min_value, res_min_ref, res_max_value, res_max_ref} !== {32'd3, 8'd1, 32'd9, 8'd2}) begin
                bad++;
                $display("FAIL stall_result: got min=%0d/%0d max=%0d/%0d, required 3/1 9/2",
                         res_min_value, res_min_ref, res_max_value, res_max_ref);
            end
            repeat (3) tick();
            total++;
            if (stall_bad != 0 || stall_left != 0) begin
                bad++;
                $display("FAIL stall_hold: got broken=%0d left=%0d, required 0 0", stall_bad, stall_left);
            end
            total++;
            if (hs_cnt - hs0 != 3 || done_cnt - d0 != 1) begin
                bad++;
                $display("FAIL stall_counts: got hs=%0d done=%0d, required 3 1", hs_cnt - hs0, done_cnt - d0);
            end
        end
        stall_ref = -1;
    endtask

    task automatic test_ref_err();
        int s, d;
        bit ok;
        vals[0] = 40; vals[1] = 5; vals[2] = 60;
        bad_ref = 1; bad_ref_val = 8'd2;
        run_scan(3, s);
        wait_done(60, d, ok);
        bad_ref = -1;
        if (ok) begin
            total++;
            if (ref_err !== 1'b1) begin
                bad++;
                $display("FAIL ref_err_set: got %b, required 1", ref_err);
            end
            tick();
            total++;
            if (res_min_value !== 32'd5 || res_min_ref !== 8'd2) begin
                bad++;
                $display("FAIL ref_err_forward: got min=%0d/%0d, required 5/2", res_min_value, res_min_ref);
            end
            repeat (3) tick();
            total++;
            if (ref_err !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL ref_err_sticky: got ref_err=%b busy=%b, required 1 0", ref_err, busy);
            end
            vals[0] = 33;
            run_scan(1, s);
            total++;
            if (ref_err !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL ref_err_clear: got ref_err=%b busy=%b, required 0 1", ref_err, busy);
            end
            wait_done(30, d, ok);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int s, d;
        bit ok;
        vals[0] = 11; vals[1] = 12;
        run_scan(1, s);
        wait_done(30, d, ok);
        if (ok) begin
            lib_size = 8'd2;
            start    = 1'b1;
            tick();
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL start_in_done: got busy=%b after done, required 0", busy);
            end
            s = cyc;
            tick();
            start = 1'b0;
            total++;
            if (busy !== 1'b1 || cmp_clear !== 1'b1) begin
                bad++;
                $display("FAIL start_after_done: got busy=%b clear=%b, required 1 1", busy, cmp_clear);
            end
            wait_done(40, d, ok);
            if (ok) begin
                total++;
                if (d - s != 2 + 2 * (1 + 2) + 1) begin
                    bad++;
                    $display("FAIL b2b_latency: got %0d, required 9", d - s);
                end
                tick();
                total++;
                if ({res_min_value, res_min_ref, res_max_value, res_max_ref} !== {32'd11, 8'd0, 32'd12, 8'd1}) begin
                    bad++;
                    $display("FAIL b2b_result: got min=%0d/%0d max=%0d/%0d, required 11/0 12/1",
                             res_min_value, res_min_ref, res_max_value, res_max_ref);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int s, d;
        bit ok;
        vals[0] = 100; vals[1] = 1; vals[2] = 200;
        ofs[1] = 1'b1;
        run_scan(3, s);
        wait_done(60, d, ok);
        ofs[1] = 1'b0;
        if (ok) begin
            tick();
            total++;
            if ({res_min_value, res_min_ref, res_max_value, res_max_ref} !== {32'd100, 8'd0, 32'd200, 8'd2}) begin
                bad++;
                $display("FAIL overflow_result: got min=%0d/%0d max=%0d/%0d, required 100/0 200/2",
                         res_min_value, res_min_ref, res_max_value, res_max_ref);
            end
        end
    endtask

    task automatic test_reset_mid();
        int s, hs0, c0;
        bit seen;
        lat = 4;
        for (int i = 0; i < 5; i++) vals[i] = WW'(i + 1);
        hs0  = hs_cnt;
        seen = 1'b0;
        run_scan(5, s);
        for (int i = 0; i < 100 && !seen; i++) begin
            if (hs_cnt - hs0 == 3) seen = 1'b1;
            else tick();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_mid_reach: got %0d handshakes, required 3", hs_cnt - hs0);
        end else begin
            tick();
            rst = 1'b1;
            sb.delete();
            tick();
            rst = 1'b0;
            total++;
            if ({busy, done, empty, ref_err, timeout, eng_req_valid, cmp_clear, cmp_in_valid} !== 8'h00) begin
                bad++;
                $display("FAIL rst_mid_ctrl: got %b, required 00000000",
                         {busy, done, empty, ref_err, timeout, eng_req_valid, cmp_clear, cmp_in_valid});
            end
            total++;
            if ({res_min_value, res_max_value, eng_req_ref} !== {32'hFFFF_FFFF, 32'h0, 8'h0}) begin
                bad++;
                $display("FAIL rst_mid_res: got min=%h max=%h req_ref=%0d, required ffffffff 0 0",
                         res_min_value, res_max_value, eng_req_ref);
            end
            c0 = cmp_cnt;
            repeat (6) tick();
            total++;
            if (cmp_cnt != c0) begin
                bad++;
                $display("FAIL rst_mid_stray: got %0d forwards, required 0", cmp_cnt - c0);
            end
        end
        lat = 2;
    endtask

`ifdef HSID_MSE_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int s, d, hs0, h;
        bit ok, seen;
        silent = 1'b1;
        hs0    = hs_cnt;
        seen   = 1'b0;
        h      = 0;
        run_scan(2, s);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (hs_cnt != hs0) begin
                seen = 1'b1;
                h    = cyc;
            end else begin
                tick();
            end
        end
        wait_done(40, d, ok);
        silent = 1'b0;
        if (ok) begin
            total++;
            if (d - h != 1 + TO || timeout !== 1'b1) begin
                bad++;
                $display("FAIL timeout_done: got wait=%0d timeout=%b, required %0d 1", d - h - 1, timeout, TO);
            end
            tick();
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL timeout_busy: got %b, required 0", busy);
            end
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        lib_size = '0;
        test_reset();
        test_basic();
        test_empty();
        test_stall();
        test_ref_err();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
`ifdef HSID_MSE_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
